// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
//   Shared helpers for the serial pattern detector and its sibling monitors.
//   calc_len_w : width needed to hold a pattern length in the range 0..seq_w
//   sat_inc    : saturating increment of a counter up to 32 bits wide
package seq_detect_pkg;

  function automatic int calc_len_w(input int seq_w);
    return $clog2(seq_w + 1);
  endfunction

  // The counter value is carried in 32 bits. For narrower counters, the
  // caller truncates the result back to its own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/seq_detect_param_pulse_stretch.sv
// pulse_stretch
//   Stretches a single-cycle trigger into a PULSE_LEN-cycle pulse using a
//   down-counter. A trigger while the pulse is active reloads the count, so
//   back-to-back triggers extend the pulse rather than stacking it.
// Ports
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear, wins over trig
//   trig   in   load PULSE_LEN into the counter
//   pulse  out  high while the counter is nonzero
module pulse_stretch #(
  parameter int PULSE_LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic trig,
  output logic pulse
);

  localparam int CW = $clog2(PULSE_LEN + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (trig) begin
      cnt <= CW'(PULSE_LEN);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign pulse = (cnt != '0);

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Serial pattern detector with a runtime-programmable pattern of 1..SEQ_W
//   bits. Selectable overlapping matching, a stretched hit pulse, and a
//   saturating hit counter. All state advances only on din_vld cycles, except
//   the pulse stretcher, which runs freely.
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   synchronous clear of history, fill, pulse and hit counter
//   din_vld  in   qualifies din
//   din      in   serial data bit
//   pattern  in   target pattern; bit pat_len-1 is received first
//   pat_len  in   active length 1..SEQ_W; other values disable detection
//   overlap  in   1 = overlapping matches, 0 = restart after each hit
//   result   out  PULSE_LEN-cycle pulse per hit (retriggerable)
//   hit_cnt  out  saturating hit count (CNT_W up to 32)
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int SEQ_W     = 8,
  parameter int PULSE_LEN = 2,
  parameter int CNT_W     = 16,
  localparam int LEN_W    = calc_len_w(SEQ_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             din_vld,
  input  logic             din,
  input  logic [SEQ_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  output logic             result,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int LW1 = LEN_W + 1;

  logic [SEQ_W-1:0] hist;
  logic [SEQ_W-1:0] hist_nxt;
  logic [LEN_W-1:0] fill;
  logic             len_ok;
  logic             fill_ok;
  logic             pat_eq;
  logic             hit;
  logic             hist_msb_unused;

  // The compare window includes the bit that is being accepted, so it matches
  // against the post-shift history. The oldest stored bit is never part of a
  // window of SEQ_W bits that includes din.
  assign hist_nxt        = {hist[SEQ_W-2:0], din};
  assign hist_msb_unused = hist[SEQ_W-1];

  always_comb begin
    pat_eq = 1'b1;
    for (int i = 0; i < SEQ_W; i++) begin
      if ((LEN_W'(i) < pat_len) && (hist_nxt[i] != pattern[i])) begin
        pat_eq = 1'b0;
      end
    end
  end

  assign len_ok  = (pat_len != '0) && (pat_len <= LEN_W'(SEQ_W));
  // The fill count guards against matching stale bits from before reset or
  // clr, or from before a non-overlapping hit.
  assign fill_ok = ({1'b0, fill} + LW1'(1)) >= {1'b0, pat_len};
  assign hit     = din_vld & len_ok & fill_ok & pat_eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      fill    <= '0;
      hit_cnt <= '0;
    end else if (clr) begin
      hist    <= '0;
      fill    <= '0;
      hit_cnt <= '0;
    end else begin
      if (din_vld) begin
        hist <= hist_nxt;
        if (hit && !overlap) begin
          fill <= '0;
        end else if (fill != LEN_W'(SEQ_W)) begin
          fill <= fill + LEN_W'(1);
        end
      end
      if (hit) begin
        hit_cnt <= CNT_W'(sat_inc(32'(hit_cnt), CNT_W));
      end
    end
  end

  pulse_stretch #(
    .PULSE_LEN(PULSE_LEN)
  ) u_pulse_stretch (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .trig (hit),
    .pulse(result)
  );

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector, the next generation of the team's fixed "10110" detector. It compares a runtime-programmable bit pattern of 1 to SEQ_W bits against a qualified serial input. Overlapping or non-overlapping matching is selectable. Each hit drives a PULSE_LEN-cycle output pulse and increments a saturating hit counter. It sits at the front of the serial-protocol monitors, fed directly by a sampled line, and for low power it updates state only on qualified input cycles.

## Interface
Parameters:
- SEQ_W, 8: maximum pattern length in bits (≥2).
- PULSE_LEN, 2: width of the `result` pulse in clk cycles (≥1).
- CNT_W, 16: width of `hit_cnt`.
- LEN_W, derived as $clog2(SEQ_W+1): width of `pat_len`; not for override.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; synchronously deasserted upstream.
- clr  in  1  synchronous clear of history, fill count, pulse and hit counter.
- din_vld  in  1  din qualifier; state advances only when high.
- din  in  1  serial data bit.
- pattern  in  SEQ_W  target; bit pat_len-1 is the first bit received, bit 0 the last.
- pat_len  in  LEN_W  active pattern length, 1..SEQ_W; 0 or >SEQ_W disables detection.
- overlap  in  1  1 = overlapping match, 0 = history flushed after each hit.
- result  out  1  high for PULSE_LEN cycles per hit (retriggerable).
- hit_cnt  out  CNT_W  saturating number of hits since reset/clr.

## Operation
- History: SEQ_W-bit shift register `hist`. On a din_vld cycle, hist <= {hist[SEQ_W-2:0], din}. There are no register toggles when din_vld=0.
- Fill counter `fill` (LEN_W bits, saturates at SEQ_W): increments on each din_vld cycle. It guarantees that no match uses bits from before reset or clr.
- Hit condition, evaluated on the edge where the bit is accepted: din_vld & pat_len valid & (fill+1 ≥ pat_len) & ({hist,din}[pat_len-1:0] == pattern[pat_len-1:0]).
- On a hit with overlap=0, fill is forced to 0 and hist is left as is (it is masked by fill). With overlap=1, fill continues normally.
- Pulse stretcher: a hit loads a down-counter with PULSE_LEN. `result` = (counter != 0). Counter decrements every clk cycle, not gated by din_vld. A hit while the counter is nonzero reloads PULSE_LEN, so the pulse extends and is never doubled.
- hit_cnt: +1 per hit; holds at all-ones.
- pattern, pat_len and overlap are quasi-static; software asserts clr after changing them. Hits in the cycle of a change use the new values, with no further guarantee.
- clr has priority over a same-cycle hit: the hit is dropped, and all of hist, fill, counter and hit_cnt go to 0.

## Timing
- Reset values: result=0, hit_cnt=0, hist=0, fill=0, stretcher=0.
- Latency: last pattern bit accepted at edge k means result=1 for the cycles after edges k..k+PULSE_LEN-1, i.e. high from edge k until edge k+PULSE_LEN. hit_cnt updates at edge k.
- Gaps in din_vld do not break a match; only qualified bits count.
- Reset asserted mid-pulse: result drops immediately (asynchronous) and no pulse resumes after release.
- Back-to-back hits (e.g. pat_len=1): result stays high continuously and falls PULSE_LEN cycles after the last hit.

## Structure
- Package seq_detect_pkg holds the LEN_W computation function and the saturating-increment function shared with sibling monitors.
- One sub-module, pulse_stretch (parameter PULSE_LEN; ports clk, rst_n, clr, trig, pulse), which the team reuses elsewhere.
- Top level: shift register, fill counter, masked comparator, hit counter. Target is 150–250 lines.

## Test plan
- pattern=5'b10110, pat_len=5, overlap=1, PULSE_LEN=2, stream 1,0,1,1,0,1,1,0 with continuous din_vld: 2 hits, after bits 5 and 8; result high 2 cycles each; hit_cnt=2.
- Same stream with overlap=0: 1 hit only, after bit 5; hit_cnt=1.
- Same stream with din_vld low for 3 cycles between every bit: identical hit count; result pulses are exactly 2 cycles and start the edge after each final bit.
- pattern=1, pat_len=1, PULSE_LEN=3, din=1 for 4 valid cycles then 0: result high for 6 consecutive cycles; hit_cnt=4.
- CNT_W=2, 5 hits: hit_cnt goes 1,2,3,3,3.
- Two cases: (a) rst_n pulled low during result high, then released, then stream 0,1,1,0, which is the tail of the pattern only; (b) clr asserted on the same cycle as a final matching bit. Required: result=0 at once in (a) and no hit in (a), since fill blocks stale history; no hit and hit_cnt=0 in (b).
